rt_mod_cnt: RTL
===============

Name: rt_mod_cnt

Overview:
Parametrised successor to the team's plain binary up/down counter. Adds a programmable modulo limit, a clock-enable prescaler and three terminal modes (wrap, saturate, one-shot), with a run/idle/halt control FSM. It produces a registered terminal-count pulse. It is used as the general timer/event counter in control paths.

Parameters:
PARAM_BIT_NUM, 8, counter and limit width W (>=2)
PARAM_PSC_NUM, 4, prescaler width P (>=1)

Ports:
rt_i_clk  in  1  clock
rt_i_rst_n  in  1  asynchronous active-low reset
rt_i_clr  in  1  synchronous clear: cnt=0, prescaler=0, state IDLE
rt_i_ld  in  1  synchronous load of rt_i_ld_val
rt_i_ld_val  in  W  load value
rt_i_start  in  1  IDLE->RUN
rt_i_stop  in  1  RUN/HALT->IDLE
rt_i_ce  in  1  count enable into prescaler
rt_i_inc_n  in  1  0: count up, 1: count down
rt_i_mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
rt_i_lim  in  W  modulo limit (terminal value up, reload value down)
rt_i_psc  in  P  prescale: one tick per (psc+1) enabled cycles
rt_o_cnt  out  W  counter value
rt_o_tc  out  1  one-cycle terminal pulse, registered
rt_o_busy  out  1  state==RUN
rt_o_eqnz  out  1  |rt_o_cnt (combinational)

Behaviour:
- Reset (rt_i_rst_n=0, async assert, sync release): cnt=0, psc_cnt=0, state=IDLE, tc=0, busy=0, eqnz=0.
- FSM states: IDLE, RUN, HALT (2-bit encoding).
- Control priority per cycle: clr > ld > stop > start > tick.
- ld: cnt<=ld_val and psc_cnt<=0. State is kept, except HALT->RUN. A tick in the same cycle is discarded.
- stop: RUN/HALT->IDLE. cnt is held and psc_cnt<=0.
- start: IDLE->RUN. Ignored in RUN/HALT. psc_cnt<=0.
- Prescaler:
  - Advances only when state==RUN and ce=1.
  - tick=1 when psc_cnt==rt_i_psc; psc_cnt then <=0.
  - psc=0 gives one tick every ce cycle.
  - psc is sampled live; if it is lowered below psc_cnt, the prescaler wraps through 2^P.
- Terminal condition, evaluated on tick:
  - up: cnt>=lim
  - down: cnt==0
- Non-terminal tick: cnt<=cnt+1 (up) or cnt-1 (down), modulo 2^W.
- Terminal tick, by mode:
  - wrap: cnt<=0 (up) or lim (down); stay RUN.
  - saturate: cnt held; RUN->HALT. No further ticks or tc until clr, ld or stop.
  - one-shot: cnt<=wrap value as above; RUN->IDLE.
- tc=1 for exactly the cycle after a terminal tick, aligned with the new cnt and state. tc=0 otherwise, including on clr, ld and stop.
- lim=0:
  - up: every tick is terminal (cnt stays 0 in wrap).
  - down: terminal every tick once cnt=0.
- Mode, inc_n and lim are sampled live at each tick; changing them mid-run is legal and takes effect at the next tick.
- Reset asserted mid-run clears everything immediately. No tc is emitted.

Decomposition:
- Shared package rt_cnt_pkg holds:
  - mode constants RT_MODE_WRAP=2'b00, RT_MODE_SAT=2'b01, RT_MODE_ONE=2'b10
  - FSM state encodings RT_ST_IDLE, RT_ST_RUN, RT_ST_HALT
- One natural sub-module, rt_psc_div: prescaler counter (clk, rst_n, clr, en, psc -> tick).
- Counter datapath and FSM stay in the top.

Test Plan:
1. Reset: assert rst_n=0 mid-run at cnt=7 -> cnt=0, tc=0, busy=0, eqnz=0 asynchronously. After release with start=1, busy=1 next cycle.
2. Up wrap: lim=5, psc=0, ce=1, start -> cnt 0,1,2,3,4,5,0,1. tc=1 only in the cycle cnt returns to 0. busy stays 1.
3. Down saturate with prescale: psc=2, ld_val=3, ld then start, ce=1 -> cnt steps 3,2,1,0 every 3 cycles. tc pulses once on reaching 0. State HALT, busy=0, cnt held 0 for 20 more cycles.
4. Up one-shot: lim=3, psc=0, start -> cnt 0,1,2,3 then 0 with tc=1 and busy=0. A second start repeats the sequence identically.
5. Priority:
   - clr+ld same cycle -> cnt=0, IDLE.
   - ld(val=9) coincident with a tick in RUN -> cnt=9, no tc.
   - ld in HALT -> RUN.
   - stop+start same cycle in IDLE -> stays IDLE.
6. Edge values:
   - up wrap lim=255 (W=8) from 254 -> 255, then 0 with tc.
   - down wrap lim=0 from cnt=0 -> tc every tick, cnt stays 0.
   - ce=0 -> no advance, prescaler frozen.

Source files
------------

// File: rtl/rt_cnt_pkg.sv
// Shared constants for the modulo counter: terminal-mode codes and control FSM states.
package rt_cnt_pkg;

  localparam logic [1:0] RT_MODE_WRAP = 2'b00;
  localparam logic [1:0] RT_MODE_SAT  = 2'b01;
  localparam logic [1:0] RT_MODE_ONE  = 2'b10;

  typedef enum logic [1:0] {
    RT_ST_IDLE = 2'b00,
    RT_ST_RUN  = 2'b01,
    RT_ST_HALT = 2'b10
  } rt_state_e;

endpackage

// File: rtl/rt_psc_div.sv
// Clock-enable prescaler: one tick per (psc+1) enabled cycles, psc sampled live.
module rt_psc_div #(
  parameter int unsigned P = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [P-1:0] psc,
  output logic         tick
);

  logic [P-1:0] psc_cnt;

  assign tick = en && (psc_cnt == psc);

  // Lowering psc below psc_cnt lets the counter run on through 2^P before matching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_cnt <= '0;
    end else if (clr) begin
      psc_cnt <= '0;
    end else if (en) begin
      psc_cnt <= tick ? '0 : psc_cnt + P'(1);
    end
  end

endmodule

// File: rtl/rt_mod_cnt.sv
// Up/down modulo counter with prescaler, wrap/saturate/one-shot terminal modes
// and a registered terminal-count pulse.
module rt_mod_cnt
  import rt_cnt_pkg::*;
#(
  parameter int unsigned PARAM_BIT_NUM = 8,
  parameter int unsigned PARAM_PSC_NUM = 4
) (
  input  logic                     rt_i_clk,
  input  logic                     rt_i_rst_n,
  input  logic                     rt_i_clr,
  input  logic                     rt_i_ld,
  input  logic [PARAM_BIT_NUM-1:0] rt_i_ld_val,
  input  logic                     rt_i_start,
  input  logic                     rt_i_stop,
  input  logic                     rt_i_ce,
  input  logic                     rt_i_inc_n,
  input  logic [1:0]               rt_i_mode,
  input  logic [PARAM_BIT_NUM-1:0] rt_i_lim,
  input  logic [PARAM_PSC_NUM-1:0] rt_i_psc,
  output logic [PARAM_BIT_NUM-1:0] rt_o_cnt,
  output logic                     rt_o_tc,
  output logic                     rt_o_busy,
  output logic                     rt_o_eqnz
);

  localparam int unsigned W = PARAM_BIT_NUM;
  localparam int unsigned P = PARAM_PSC_NUM;

  rt_state_e    state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] wrap_val;
  logic         tc_q, tc_d;
  logic         busy_q;
  logic         psc_clr, psc_en, tick, term;

  assign psc_en   = (state_q == RT_ST_RUN) && rt_i_ce;
  assign term     = rt_i_inc_n ? (cnt_q == '0) : (cnt_q >= rt_i_lim);
  assign wrap_val = rt_i_inc_n ? rt_i_lim : '0;

  rt_psc_div #(.P(P)) u_psc_div (
    .clk   (rt_i_clk),
    .rst_n (rt_i_rst_n),
    .clr   (psc_clr),
    .en    (psc_en),
    .psc   (rt_i_psc),
    .tick  (tick)
  );

  // Control priority: clr > ld > stop > start > tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    psc_clr = 1'b0;
    if (rt_i_clr) begin
      cnt_d   = '0;
      state_d = RT_ST_IDLE;
      psc_clr = 1'b1;
    end else if (rt_i_ld) begin
      cnt_d   = rt_i_ld_val;
      psc_clr = 1'b1;
      if (state_q == RT_ST_HALT) state_d = RT_ST_RUN;
    end else if (rt_i_stop) begin
      state_d = RT_ST_IDLE;
      psc_clr = 1'b1;
    end else if (rt_i_start && (state_q == RT_ST_IDLE)) begin
      state_d = RT_ST_RUN;
      psc_clr = 1'b1;
    end else if (tick) begin
      if (!term) begin
        cnt_d = rt_i_inc_n ? cnt_q - W'(1) : cnt_q + W'(1);
      end else begin
        tc_d = 1'b1;
        case (rt_i_mode)
          RT_MODE_WRAP: cnt_d = wrap_val;
          RT_MODE_SAT:  state_d = RT_ST_HALT;
          RT_MODE_ONE: begin
            cnt_d   = wrap_val;
            state_d = RT_ST_IDLE;
          end
          default:      cnt_d = wrap_val;
        endcase
      end
    end
  end

  always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
    if (!rt_i_rst_n) begin
      state_q <= RT_ST_IDLE;
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      busy_q  <= (state_d == RT_ST_RUN);
    end
  end

  assign rt_o_cnt  = cnt_q;
  assign rt_o_tc   = tc_q;
  assign rt_o_busy = busy_q;
  assign rt_o_eqnz = |cnt_q;

endmodule
